counter_seq_monitor: RTL and testbench

//   Consumer side of the lab counter interface: samples a free-running modulo

---
 rtl/counter_seq_monitor.sv | 167 ++++++++++++++++
 tb/tb_counter_seq_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_monitor.sv
// Consumer-side monitor for a free-running modulo counter bus: locks after SYNC_LEN good steps, flags and counts slips.
// Build option COUNTER_MON_STICKY_EN: a locked-state mismatch latches a sticky fault instead of resynchronising.
module counter_seq_monitor #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 15,
    parameter int SYNC_LEN = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] y_in,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic             fault,
    output logic [ERR_W-1:0] err_count
);

    localparam int              MC_W    = $clog2(SYNC_LEN + 1);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
    // Widened by one bit so the range check never degenerates to a constant compare.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_VAL);
    localparam logic [MC_W-1:0]  SYNC_V  = MC_W'(SYNC_LEN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
`ifdef COUNTER_MON_STICKY_EN
        S_LOCKED = 2'd2,
        S_FAULT  = 2'd3
`else
        S_LOCKED = 2'd2
`endif
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] expected_q;
    logic [MC_W-1:0]  mcnt_q;
    logic             locked_q;
    logic             err_q;
    logic             wrap_q;
    logic [ERR_W-1:0] err_count_q;

    logic             in_range_s;
    logic             match_s;
    logic [WIDTH-1:0] expected_d;
    logic [MC_W-1:0]  mcnt_d;
    logic [ERR_W-1:0] err_count_d;

    // Classify the current sample and precompute the next-state candidates.
    always_comb begin
        in_range_s = ({1'b0, y_in} <= MAX_EXT);
        match_s    = in_range_s && (y_in == expected_q);
        if (y_in == MAX_V) begin
            expected_d = {WIDTH{1'b0}};
        end else begin
            expected_d = y_in + WIDTH'(1);
        end
        mcnt_d = mcnt_q + MC_W'(1);
        if (&err_count_q) begin
            err_count_d = err_count_q;
        end else begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

`ifdef COUNTER_MON_STICKY_EN
    logic fault_q;
`endif

    // Monitor FSM with registered status outputs; err/wrap are single-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            expected_q  <= {WIDTH{1'b0}};
            mcnt_q      <= {MC_W{1'b0}};
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
            err_count_q <= {ERR_W{1'b0}};
`ifdef COUNTER_MON_STICKY_EN
            fault_q     <= 1'b0;
`endif
        end else if (!en) begin
            err_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_range_s) begin
                        state_q    <= S_SYNC;
                        expected_q <= expected_d;
                        mcnt_q     <= {MC_W{1'b0}};
                    end
                end
                S_SYNC: begin
                    if (match_s) begin
                        expected_q <= expected_d;
                        if (mcnt_d == SYNC_V) begin
                            state_q  <= S_LOCKED;
                            locked_q <= 1'b1;
                            mcnt_q   <= {MC_W{1'b0}};
                        end else begin
                            mcnt_q <= mcnt_d;
                        end
                    end else if (in_range_s) begin
                        expected_q <= expected_d;
                        mcnt_q     <= {MC_W{1'b0}};
                    end else begin
                        // An out-of-range value gives nothing to predict from; start over.
                        state_q    <= S_IDLE;
                        expected_q <= {WIDTH{1'b0}};
                        mcnt_q     <= {MC_W{1'b0}};
                    end
                end
                S_LOCKED: begin
                    if (match_s) begin
                        expected_q <= expected_d;
                        wrap_q     <= (y_in == {WIDTH{1'b0}});
                    end else begin
                        err_q       <= 1'b1;
                        err_count_q <= err_count_d;
                        locked_q    <= 1'b0;
                        mcnt_q      <= {MC_W{1'b0}};
`ifdef COUNTER_MON_STICKY_EN
                        state_q     <= S_FAULT;
                        fault_q     <= 1'b1;
`else
                        if (in_range_s) begin
                            state_q    <= S_SYNC;
                            expected_q <= expected_d;
                        end else begin
                            state_q    <= S_IDLE;
                            expected_q <= {WIDTH{1'b0}};
                        end
`endif
                    end
                end
`ifdef COUNTER_MON_STICKY_EN
                S_FAULT: begin
                    state_q  <= S_FAULT;
                    locked_q <= 1'b0;
                end
`endif
                default: begin
                    state_q  <= S_IDLE;
                    locked_q <= 1'b0;
                    mcnt_q   <= {MC_W{1'b0}};
                end
            endcase
        end
    end

    assign locked    = locked_q;
    assign err       = err_q;
    assign wrap      = wrap_q;
    assign err_count = err_count_q;
`ifdef COUNTER_MON_STICKY_EN
    assign fault     = fault_q;
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_counter_seq_monitor.sv
// Randomized and directed bench for counter_seq_monitor against a run-length reference model.
// Instance a: WIDTH=4 MAX_VAL=15 ERR_W=8; instance b: WIDTH=4 MAX_VAL=9 ERR_W=2.
module tb_counter_seq_monitor;

    localparam int SYNC = 3;
`ifdef COUNTER_MON_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_a, en_b;
    logic [3:0] y_a, y_b;
    logic       lk_a, er_a, wr_a, ft_a;
    logic       lk_b, er_b, wr_b, ft_b;
    logic [7:0] ec_a;
    logic [1:0] ec_b;

    always #5 clk = ~clk;

    counter_seq_monitor #(.WIDTH(4), .MAX_VAL(15), .SYNC_LEN(SYNC), .ERR_W(8)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .y_in(y_a),
        .locked(lk_a), .err(er_a), .wrap(wr_a), .fault(ft_a), .err_count(ec_a)
    );

    counter_seq_monitor #(.WIDTH(4), .MAX_VAL(9), .SYNC_LEN(SYNC), .ERR_W(2)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .y_in(y_b),
        .locked(lk_b), .err(er_b), .wrap(wr_b), .fault(ft_b), .err_count(ec_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: history of samples reduced to "last value, run of good steps".
    int m_max[2] = '{15, 9};
    int m_sat[2] = '{255, 3};
    bit m_has[2];
    int m_prev[2];
    int m_run[2];
    bit m_lock[2];
    bit m_fault[2];
    int m_errs[2];
    bit m_err[2];
    bit m_wrap[2];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_has[i] = 0; m_prev[i] = 0; m_run[i] = 0; m_lock[i] = 0;
            m_fault[i] = 0; m_errs[i] = 0; m_err[i] = 0; m_wrap[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit e, input int y);
        bit inr, good;
        int nxt;
        m_err[i]  = 0;
        m_wrap[i] = 0;
        if (e && !m_fault[i]) begin
            inr  = (y <= m_max[i]);
            nxt  = (m_prev[i] == m_max[i]) ? 0 : m_prev[i] + 1;
            good = inr && m_has[i] && (y == nxt);
            if (m_lock[i]) begin
                if (good) begin
                    m_wrap[i] = (y == 0);
                end else begin
                    m_err[i]  = 1;
                    m_errs[i] = (m_errs[i] < m_sat[i]) ? m_errs[i] + 1 : m_sat[i];
                    m_lock[i] = 0;
                    m_run[i]  = 0;
                    if (STICKY) m_fault[i] = 1;
                end
            end else if (good) begin
                m_run[i]++;
                if (m_run[i] == SYNC) m_lock[i] = 1;
            end else begin
                m_run[i] = 0;
            end
            if (!good) m_has[i] = inr;
            m_prev[i] = y;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_a_locked"}, lk_a, m_lock[0]);
        check_eq({tag, "_a_err"},    er_a, m_err[0]);
        check_eq({tag, "_a_wrap"},   wr_a, m_wrap[0]);
        check_eq({tag, "_a_fault"},  ft_a, m_fault[0]);
        check_eq({tag, "_a_errcnt"}, ec_a, m_errs[0]);
        check_eq({tag, "_b_locked"}, lk_b, m_lock[1]);
        check_eq({tag, "_b_err"},    er_b, m_err[1]);
        check_eq({tag, "_b_wrap"},   wr_b, m_wrap[1]);
        check_eq({tag, "_b_fault"},  ft_b, m_fault[1]);
        check_eq({tag, "_b_errcnt"}, ec_b, m_errs[1]);
    endtask

    // Called on a falling edge: drive, clock, step the model, compare.
    task automatic drv(input bit ea, input int ya, input bit eb, input int yb, input string tag);
        en_a = ea; y_a = 4'(ya);
        en_b = eb; y_b = 4'(yb);
        @(posedge clk);
        model_step(0, ea, ya);
        model_step(1, eb, yb);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    int na, nb, r;
    bit ea, eb;
    int ya, yb;

    initial begin
        en_a = 1'b0; en_b = 1'b0; y_a = 4'd0; y_b = 4'd0;
        model_reset();
        #1 rst = 1'b0;
        #10;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Straight count 0..15,0: lock after the third increment, wrap on 15->0.
        for (int v = 0; v <= 15; v++) begin
            drv(1'b1, v, 1'b0, 0, "t1");
            if (v == 2) check_eq("t1_not_yet_locked", lk_a, 0);
            if (v == 3) check_eq("t1_locked_at3", lk_a, 1);
        end
        drv(1'b1, 0, 1'b0, 0, "t1w");
        check_eq("t1_wrap", wr_a, 1);
        check_eq("t1_errcnt", ec_a, 0);

        // Slip while locked.
        for (int v = 1; v <= 4; v++) drv(1'b1, v, 1'b0, 0, "t2");
        drv(1'b1, 7, 1'b0, 0, "t2e");
        check_eq("t2_err", er_a, 1);
        check_eq("t2_errcnt", ec_a, 1);
        check_eq("t2_unlocked", lk_a, 0);
        for (int v = 8; v <= 11; v++) drv(1'b1, v, 1'b0, 0, "t2r");
        if (!STICKY) check_eq("t2_relocked", lk_a, 1);

        // Enable low while the bus jumps around, then resume with the right value.
        for (int k = 0; k < 5; k++) drv(1'b0, $urandom_range(0, 15), 1'b0, 0, "t3");
        drv(1'b1, 12, 1'b0, 0, "t3r");
        check_eq("t3_no_err", er_a, 0);

        // Small modulus: out-of-range after terminal count, then saturate err_count.
        for (int v = 0; v <= 9; v++) drv(1'b0, 0, 1'b1, v, "t4");
        drv(1'b0, 0, 1'b1, 10, "t4e");
        check_eq("t4_err", er_b, 1);
        for (int f = 0; f < 5; f++) begin
            for (int v = 0; v <= 3; v++) drv(1'b0, 0, 1'b1, v, "t4l");
            drv(1'b0, 0, 1'b1, 9, "t4f");
        end
        check_eq("t4_saturated", ec_b, STICKY ? 1 : 3);

        // Second slip on instance a, relock, then async reset between edges.
        drv(1'b1, 5, 1'b0, 0, "t5e");
        for (int v = 6; v <= 9; v++) drv(1'b1, v, 1'b0, 0, "t5l");
        if (!STICKY) check_eq("t5_errcnt_pre", ec_a, 2);
        en_a = 1'b0; en_b = 1'b0;
        rst = 1'b0;
        #2;
        model_reset();
        check_eq("t5_async_locked", lk_a, 0);
        check_eq("t5_async_errcnt", ec_a, 0);
        check_all("t5");
        @(negedge clk);
        rst = 1'b1;

`ifdef COUNTER_MON_STICKY_EN
        for (int v = 0; v <= 3; v++) drv(1'b1, v, 1'b0, 0, "t6l");
        drv(1'b1, 9, 1'b0, 0, "t6e");
        for (int v = 10; v < 30; v++) drv(1'b1, v % 16, 1'b0, 0, "t6");
        check_eq("t6_fault", ft_a, 1);
        check_eq("t6_errcnt", ec_a, 1);
        check_eq("t6_locked", lk_a, 0);
`endif

        // Randomized: mostly clean counting, with disabled cycles and random jumps.
        na = 0; nb = 0;
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 23);
            ea = (r != 0);
            ya = (r <= 1) ? $urandom_range(0, 15) : na;
            r = $urandom_range(0, 23);
            eb = (r != 0);
            yb = (r <= 1) ? $urandom_range(0, 15) : nb;
            if (ea) na = (ya >= 15) ? 0 : ya + 1;
            if (eb) nb = (yb >= 9) ? 0 : yb + 1;
            drv(ea, ya, eb, yb, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
